x86_prefix_decoder: RTL and testbench
=====================================

Name: x86_prefix_decoder

Overview:
- Parametrised front-end for the x86 core that consumes an instruction byte stream one byte per cycle.
- Absorbs legacy prefixes (segment, 66, 67, F0, F2/F3) and the 0F escape, enforces the architectural instruction-length limit, and tracks the byte pointer.
- Hands a decoded instruction header to the execute sequencer over a valid/ready handshake.
- Sits between the byte-fetch path (memory mux) and the main execution FSM; replaces the inline prefix cycles of the sequencer.

Parameters:
- IPW, 32, width of instruction pointer.
- MAX_LEN, 15, maximum bytes consumed before opcode (prefixes + escape + opcode); 2..15.
- LENW, 4, width of length counter; must hold MAX_LEN.

Ports:
- clock  in  1  core clock (25 MHz).
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  abort current decode, load new_ip.
- new_ip  in  IPW  restart pointer, sampled when flush=1.
- def_opsize  in  1  default operand size (1=32-bit), sampled at instruction start.
- def_adsize  in  1  default address size (1=32-bit), sampled at instruction start.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  instruction byte at current ip.
- in_ready  out  1  decoder accepts byte this cycle.
- ip  out  IPW  address of next byte to fetch.
- hdr_valid  out  1  header valid.
- hdr_ready  in  1  execute sequencer accepts header.
- opcode  out  9  {escape, byte}; bit8=1 after 0F.
- seg_id  out  3  0 ES, 1 CS, 2 SS, 3 DS, 4 FS, 5 GS.
- seg_pre  out  1  segment override present.
- opsize  out  1  effective operand size.
- adsize  out  1  effective address size.
- rep  out  2  00 none, 10 REPNZ (F2), 11 REPZ (F3).
- lock  out  1  F0 seen.
- len  out  LENW  bytes consumed incl. opcode.
- start_ip  out  IPW  ip of first byte of instruction.
- fault  out  1  length limit hit before opcode (#UD/#GP source).

Behaviour:
- Reset: state PFX; in_ready=1; hdr_valid=0; ip=0; opcode=0; seg_id=3; seg_pre=0; opsize=0; adsize=0; rep=0; lock=0; len=0; start_ip=0; fault=0.
- States: PFX (expect prefix/escape/opcode), ESC (after 0F), HOLD (header presented).
- in_ready=1 in PFX/ESC, 0 in HOLD.
- Byte accepted when in_valid & in_ready.
- Each accepted byte: ip<=ip+1 (wraps at 2^IPW); len<=len+1.
- First accepted byte of an instruction (len==0): start_ip<=ip; seg_id<=3, seg_pre<=0, rep<=0, lock<=0, opsize<=def_opsize, adsize<=def_adsize; that byte's own effect is applied on top of these defaults.
- PFX decode:
  - 26/2E/36/3E: seg_id<=byte[4:3], seg_pre<=1.
  - 64/65: seg_id<=4+byte[0], seg_pre<=1.
  - 66: opsize<=~def_opsize. 67: adsize<=~def_adsize. Repeats are idempotent, not toggling.
  - F0: lock<=1. F2/F3: rep<={1,byte[0]}.
  - Last segment/rep prefix wins.
  - 0F -> ESC.
  - Any other byte: opcode<={0,byte}; hdr_valid<=1; -> HOLD.
- ESC: any byte -> opcode<={1,byte}; hdr_valid<=1; -> HOLD. Prefixes are not re-decoded in ESC.
- Length limit: if a non-opcode byte is accepted and len+1==MAX_LEN:
  - fault<=1, hdr_valid<=1, opcode<=0, -> HOLD.
  - An opcode byte arriving exactly at MAX_LEN is legal (fault=0).
- HOLD: outputs stable until hdr_valid & hdr_ready. Then hdr_valid<=0, len<=0, fault<=0, -> PFX.
- Latency: header valid the cycle after the opcode byte is accepted. Min throughput: one 1-byte instruction per 2 cycles.
- flush (priority over all): next cycle state=PFX, ip<=new_ip, len<=0, hdr_valid<=0, fault<=0. Any byte presented the same cycle is dropped.
- in_valid=0: state holds, nothing advances.
- Async reset mid-decode returns to reset values immediately.

Decomposition:
- Shared package cpu_pkg: SEG_ES..SEG_GS constants, REP_NONE/REP_NZ/REP_Z, prefix byte constants (PFX_OPSZ=66, PFX_ADSZ=67, PFX_LOCK=F0, ESC_0F=0F), decoder state enum.
- One natural sub-module: x86_prefix_classify. Purely combinational byte -> {is_seg, seg_code, is_opsz, is_adsz, is_lock, is_rep, rep_code, is_esc}.

Test Plan:
- def_opsize=0; bytes 2E 66 F3 A5 from ip=100 -> hdr: opcode=0A5, seg_id=1, seg_pre=1, opsize=1, rep=11, len=4, start_ip=100; ip=104.
- Bytes 64 0F B6, hdr_ready held 0 for 3 cycles -> opcode=1B6, seg_id=4, len=3; outputs stable and in_ready=0 while held.
- 15 bytes of 26 -> fault=1, len=15. Then 14x 26 + 90 -> fault=0, opcode=090, len=15.
- Bytes 66 66 F2 F3 3E 36 90, def_opsize=1 -> opsize=0, rep=11, seg_id=2.
- flush with new_ip=FFFF_FFFF after bytes 2E 0F; then byte C3 -> opcode=0C3, seg_pre=0, start_ip=FFFF_FFFF, ip wraps to 0.
- reset_n pulsed low mid-HOLD -> hdr_valid=0, ip=0 asynchronously; in_valid gaps between prefix bytes -> same header as gap-free run.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared x86 front-end definitions: segment/rep encodings, prefix byte values,
// prefix-decoder state and the per-byte classification record.
package cpu_pkg;

  localparam logic [2:0] SEG_ES = 3'd0;
  localparam logic [2:0] SEG_CS = 3'd1;
  localparam logic [2:0] SEG_SS = 3'd2;
  localparam logic [2:0] SEG_DS = 3'd3;
  localparam logic [2:0] SEG_FS = 3'd4;
  localparam logic [2:0] SEG_GS = 3'd5;

  localparam logic [1:0] REP_NONE = 2'b00;
  localparam logic [1:0] REP_NZ   = 2'b10;
  localparam logic [1:0] REP_Z    = 2'b11;

  localparam logic [7:0] PFX_ES    = 8'h26;
  localparam logic [7:0] PFX_CS    = 8'h2E;
  localparam logic [7:0] PFX_SS    = 8'h36;
  localparam logic [7:0] PFX_DS    = 8'h3E;
  localparam logic [7:0] PFX_FS    = 8'h64;
  localparam logic [7:0] PFX_GS    = 8'h65;
  localparam logic [7:0] PFX_OPSZ  = 8'h66;
  localparam logic [7:0] PFX_ADSZ  = 8'h67;
  localparam logic [7:0] PFX_LOCK  = 8'hF0;
  localparam logic [7:0] PFX_REPNZ = 8'hF2;
  localparam logic [7:0] PFX_REPZ  = 8'hF3;
  localparam logic [7:0] ESC_0F    = 8'h0F;

  typedef enum logic [1:0] {
    ST_PFX  = 2'd0,
    ST_ESC  = 2'd1,
    ST_HOLD = 2'd2
  } dec_state_e;

  typedef struct packed {
    logic       is_seg;
    logic [2:0] seg_code;
    logic       is_opsz;
    logic       is_adsz;
    logic       is_lock;
    logic       is_rep;
    logic [1:0] rep_code;
    logic       is_esc;
  } pfx_class_t;

  // Anything that is not a prefix or the escape terminates the header.
  function automatic logic any_prefix(input pfx_class_t c);
    return c.is_seg | c.is_opsz | c.is_adsz | c.is_lock | c.is_rep | c.is_esc;
  endfunction

endpackage

// File: rtl/x86_prefix_decoder_if.sv
// Byte-stream input and decoded-header output bundle of the prefix decoder.
// master = fetch/sequencer side, slave = decoder.
interface x86_prefix_decoder_if #(
  parameter int IPW  = 32,
  parameter int LENW = 4
);
  logic            flush;
  logic [IPW-1:0]  new_ip;
  logic            def_opsize;
  logic            def_adsize;
  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_ready;
  logic [IPW-1:0]  ip;
  logic            hdr_valid;
  logic            hdr_ready;
  logic [8:0]      opcode;
  logic [2:0]      seg_id;
  logic            seg_pre;
  logic            opsize;
  logic            adsize;
  logic [1:0]      rep;
  logic            lock;
  logic [LENW-1:0] len;
  logic [IPW-1:0]  start_ip;
  logic            fault;

  modport master (
    output flush, new_ip, def_opsize, def_adsize, in_valid, in_data, hdr_ready,
    input  in_ready, ip, hdr_valid, opcode, seg_id, seg_pre, opsize, adsize,
           rep, lock, len, start_ip, fault
  );

  modport slave (
    input  flush, new_ip, def_opsize, def_adsize, in_valid, in_data, hdr_ready,
    output in_ready, ip, hdr_valid, opcode, seg_id, seg_pre, opsize, adsize,
           rep, lock, len, start_ip, fault
  );
endinterface

// File: rtl/x86_prefix_classify.sv
// Combinational classification of one instruction byte into prefix kinds.
module x86_prefix_classify
  import cpu_pkg::*;
(
  input  logic [7:0] in_byte,
  output pfx_class_t cls
);

  always_comb begin
    cls = '0;
    case (in_byte)
      PFX_ES:    begin cls.is_seg = 1'b1; cls.seg_code = SEG_ES; end
      PFX_CS:    begin cls.is_seg = 1'b1; cls.seg_code = SEG_CS; end
      PFX_SS:    begin cls.is_seg = 1'b1; cls.seg_code = SEG_SS; end
      PFX_DS:    begin cls.is_seg = 1'b1; cls.seg_code = SEG_DS; end
      PFX_FS:    begin cls.is_seg = 1'b1; cls.seg_code = SEG_FS; end
      PFX_GS:    begin cls.is_seg = 1'b1; cls.seg_code = SEG_GS; end
      PFX_OPSZ:  cls.is_opsz = 1'b1;
      PFX_ADSZ:  cls.is_adsz = 1'b1;
      PFX_LOCK:  cls.is_lock = 1'b1;
      PFX_REPNZ: begin cls.is_rep = 1'b1; cls.rep_code = REP_NZ; end
      PFX_REPZ:  begin cls.is_rep = 1'b1; cls.rep_code = REP_Z; end
      ESC_0F:    cls.is_esc = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/x86_prefix_decoder.sv
// x86 legacy-prefix / 0F-escape front end: one byte per cycle in, one decoded
// instruction header out over valid/ready, with length-limit fault detection.
module x86_prefix_decoder
  import cpu_pkg::*;
#(
  parameter int IPW     = 32,
  parameter int MAX_LEN = 15,
  parameter int LENW    = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  x86_prefix_decoder_if.slave  bus
);

  localparam logic [LENW-1:0] LEN_LIMIT = LENW'(MAX_LEN);

  dec_state_e      state_q, state_d;
  logic [IPW-1:0]  ip_q, ip_d;
  logic [IPW-1:0]  start_ip_q, start_ip_d;
  logic [LENW-1:0] len_q, len_d;
  logic [8:0]      opcode_q, opcode_d;
  logic [2:0]      seg_id_q, seg_id_d;
  logic            seg_pre_q, seg_pre_d;
  logic            opsize_q, opsize_d;
  logic            adsize_q, adsize_d;
  logic [1:0]      rep_q, rep_d;
  logic            lock_q, lock_d;
  logic            hdr_valid_q, hdr_valid_d;
  logic            fault_q, fault_d;

  logic            in_ready;
  logic [LENW-1:0] len_inc;
  pfx_class_t      cls;

  x86_prefix_classify u_classify (
    .in_byte (bus.in_data),
    .cls     (cls)
  );

  assign in_ready = (state_q != ST_HOLD);
  assign len_inc  = len_q + LENW'(1);

  always_comb begin
    state_d     = state_q;
    ip_d        = ip_q;
    start_ip_d  = start_ip_q;
    len_d       = len_q;
    opcode_d    = opcode_q;
    seg_id_d    = seg_id_q;
    seg_pre_d   = seg_pre_q;
    opsize_d    = opsize_q;
    adsize_d    = adsize_q;
    rep_d       = rep_q;
    lock_d      = lock_q;
    hdr_valid_d = hdr_valid_q;
    fault_d     = fault_q;

    if (bus.flush) begin
      state_d     = ST_PFX;
      ip_d        = bus.new_ip;
      len_d       = '0;
      hdr_valid_d = 1'b0;
      fault_d     = 1'b0;
    end else begin
      case (state_q)
        ST_PFX, ST_ESC: begin
          if (bus.in_valid) begin
            ip_d  = ip_q + IPW'(1);
            len_d = len_inc;
            // A new instruction starts from architectural defaults; this
            // byte's own prefix effect is layered on below.
            if (len_q == '0) begin
              start_ip_d = ip_q;
              seg_id_d   = SEG_DS;
              seg_pre_d  = 1'b0;
              rep_d      = REP_NONE;
              lock_d     = 1'b0;
              opsize_d   = bus.def_opsize;
              adsize_d   = bus.def_adsize;
            end
            if (state_q == ST_ESC) begin
              opcode_d    = {1'b1, bus.in_data};
              hdr_valid_d = 1'b1;
              state_d     = ST_HOLD;
            end else begin
              if (cls.is_seg) begin
                seg_id_d  = cls.seg_code;
                seg_pre_d = 1'b1;
              end
              if (cls.is_opsz) opsize_d = ~bus.def_opsize;
              if (cls.is_adsz) adsize_d = ~bus.def_adsize;
              if (cls.is_lock) lock_d   = 1'b1;
              if (cls.is_rep)  rep_d    = cls.rep_code;
              if (cls.is_esc)  state_d  = ST_ESC;
              if (!any_prefix(cls)) begin
                opcode_d    = {1'b0, bus.in_data};
                hdr_valid_d = 1'b1;
                state_d     = ST_HOLD;
              end else if (len_inc == LEN_LIMIT) begin
                fault_d     = 1'b1;
                opcode_d    = '0;
                hdr_valid_d = 1'b1;
                state_d     = ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          if (bus.hdr_ready) begin
            hdr_valid_d = 1'b0;
            len_d       = '0;
            fault_d     = 1'b0;
            state_d     = ST_PFX;
          end
        end
        default: state_d = ST_PFX;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_PFX;
      ip_q        <= '0;
      start_ip_q  <= '0;
      len_q       <= '0;
      opcode_q    <= '0;
      seg_id_q    <= SEG_DS;
      seg_pre_q   <= 1'b0;
      opsize_q    <= 1'b0;
      adsize_q    <= 1'b0;
      rep_q       <= REP_NONE;
      lock_q      <= 1'b0;
      hdr_valid_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ip_q        <= ip_d;
      start_ip_q  <= start_ip_d;
      len_q       <= len_d;
      opcode_q    <= opcode_d;
      seg_id_q    <= seg_id_d;
      seg_pre_q   <= seg_pre_d;
      opsize_q    <= opsize_d;
      adsize_q    <= adsize_d;
      rep_q       <= rep_d;
      lock_q      <= lock_d;
      hdr_valid_q <= hdr_valid_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.ip        = ip_q;
  assign bus.start_ip  = start_ip_q;
  assign bus.len       = len_q;
  assign bus.opcode    = opcode_q;
  assign bus.seg_id    = seg_id_q;
  assign bus.seg_pre   = seg_pre_q;
  assign bus.opsize    = opsize_q;
  assign bus.adsize    = adsize_q;
  assign bus.rep       = rep_q;
  assign bus.lock      = lock_q;
  assign bus.hdr_valid = hdr_valid_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_x86_prefix_decoder.sv
// Bench for x86_prefix_decoder: directed vector table, hand-written corner
// sequences, and randomized instructions checked against a byte-rule model.
module tb_x86_prefix_decoder;

  typedef struct packed {
    logic        fault;
    logic [8:0]  opcode;
    logic [2:0]  seg_id;
    logic        seg_pre;
    logic        opsize;
    logic        adsize;
    logic [1:0]  rep;
    logic        lock;
    logic [3:0]  len;
    logic [31:0] start_ip;
    logic [31:0] ip;
  } hdr_t;

  typedef struct packed {
    logic [31:0]  ip0;
    logic [4:0]   n;
    logic [127:0] b;
    logic         dop;
    logic         dad;
    hdr_t         exp;
  } tv_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  x86_prefix_decoder_if #(.IPW(32), .LENW(4)) bus ();

  x86_prefix_decoder #(.IPW(32), .MAX_LEN(15), .LENW(4)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] pool [12] = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
                            8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3, 8'h0F};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Byte i of an n-byte sequence stored right-aligned, first byte leftmost.
  function automatic logic [7:0] gb(input logic [127:0] s, input int n, input int i);
    return s[8*(n-1-i) +: 8];
  endfunction

  function automatic hdr_t mk(input logic [8:0] opc, input logic [2:0] seg, input logic pre,
                              input logic ops, input logic ads, input logic [1:0] rp,
                              input logic lk, input logic [3:0] ln, input logic [31:0] st,
                              input logic flt);
    hdr_t h;
    h.fault = flt; h.opcode = opc; h.seg_id = seg; h.seg_pre = pre;
    h.opsize = ops; h.adsize = ads; h.rep = rp; h.lock = lk;
    h.len = ln; h.start_ip = st; h.ip = st + 32'(ln);
    return h;
  endfunction

  // Reference: walk the bytes applying the architectural prefix rules.
  function automatic hdr_t model(input logic [127:0] s, input int n, input logic dop,
                                 input logic dad, input logic [31:0] ip0, output int used);
    hdr_t h;
    bit   esc, done, is_pfx;
    logic [7:0] x;
    h = mk(9'h000, 3'd3, 1'b0, dop, dad, 2'b00, 1'b0, 4'd0, ip0, 1'b0);
    esc = 0; done = 0; used = 0;
    for (int i = 0; i < n; i++) begin
      if (!done) begin
        x = gb(s, n, i);
        used = i + 1;
        if (esc) begin
          h.opcode = {1'b1, x};
          done = 1;
        end else begin
          is_pfx = 1;
          case (x)
            8'h26: begin h.seg_id = 3'd0; h.seg_pre = 1; end
            8'h2E: begin h.seg_id = 3'd1; h.seg_pre = 1; end
            8'h36: begin h.seg_id = 3'd2; h.seg_pre = 1; end
            8'h3E: begin h.seg_id = 3'd3; h.seg_pre = 1; end
            8'h64: begin h.seg_id = 3'd4; h.seg_pre = 1; end
            8'h65: begin h.seg_id = 3'd5; h.seg_pre = 1; end
            8'h66: h.opsize = !dop;
            8'h67: h.adsize = !dad;
            8'hF0: h.lock = 1;
            8'hF2: h.rep = 2'b10;
            8'hF3: h.rep = 2'b11;
            8'h0F: esc = 1;
            default: is_pfx = 0;
          endcase
          if (!is_pfx) begin
            h.opcode = {1'b0, x};
            done = 1;
          end else if (used == 15) begin
            h.fault = 1; h.opcode = 9'h000;
            done = 1;
          end
        end
      end
    end
    h.len = 4'(used);
    h.ip = ip0 + 32'(used);
    return h;
  endfunction

  task automatic do_flush(input logic [31:0] nip);
    bus.flush = 1'b1; bus.new_ip = nip;
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  task automatic feed(input logic [127:0] s, input int n, input int cnt, input bit gaps);
    int t;
    for (int i = 0; i < cnt; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = gb(s, n, i);
      t = 0;
      while (!bus.in_ready && t < 20) begin @(posedge clk); #1; t++; end
      chk("feed_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic take_hdr(output hdr_t h, input int delay);
    int t = 0;
    while (!bus.hdr_valid && t < 20) begin @(posedge clk); #1; t++; end
    chk("hdr_wait", 64'(bus.hdr_valid), 64'd1);
    repeat (delay) begin @(posedge clk); #1; end
    h.fault = bus.fault; h.opcode = bus.opcode; h.seg_id = bus.seg_id;
    h.seg_pre = bus.seg_pre; h.opsize = bus.opsize; h.adsize = bus.adsize;
    h.rep = bus.rep; h.lock = bus.lock; h.len = bus.len;
    h.start_ip = bus.start_ip; h.ip = bus.ip;
    bus.hdr_ready = 1'b1;
    @(posedge clk); #1;
    bus.hdr_ready = 1'b0;
  endtask

  task automatic cmp_hdr(input string tag, input hdr_t a, input hdr_t e);
    chk({tag, ".fault"},    64'(a.fault),    64'(e.fault));
    chk({tag, ".opcode"},   64'(a.opcode),   64'(e.opcode));
    chk({tag, ".len"},      64'(a.len),      64'(e.len));
    chk({tag, ".start_ip"}, 64'(a.start_ip), 64'(e.start_ip));
    chk({tag, ".ip"},       64'(a.ip),       64'(e.ip));
    if (!e.fault) begin
      chk({tag, ".seg_id"},  64'(a.seg_id),  64'(e.seg_id));
      chk({tag, ".seg_pre"}, 64'(a.seg_pre), 64'(e.seg_pre));
      chk({tag, ".opsize"},  64'(a.opsize),  64'(e.opsize));
      chk({tag, ".adsize"},  64'(a.adsize),  64'(e.adsize));
      chk({tag, ".rep"},     64'(a.rep),     64'(e.rep));
      chk({tag, ".lock"},    64'(a.lock),    64'(e.lock));
    end
  endtask

  tv_t  tv [12];
  hdr_t got, exp_h;

  initial begin
    int used;
    logic [127:0] s;
    logic [31:0]  ip0;
    logic dop, dad;

    n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    bus.flush = 0; bus.new_ip = '0; bus.def_opsize = 0; bus.def_adsize = 0;
    bus.in_valid = 0; bus.in_data = '0; bus.hdr_ready = 0;

    tv[0]  = '{ip0: 32'h100, n: 5'd4, b: {8'h2E, 8'h66, 8'hF3, 8'hA5}, dop: 0, dad: 0,
               exp: mk(9'h0A5, 3'd1, 1, 1, 0, 2'b11, 0, 4'd4, 32'h100, 0)};
    tv[1]  = '{ip0: 32'h1000, n: 5'd3, b: {8'h64, 8'h0F, 8'hB6}, dop: 0, dad: 0,
               exp: mk(9'h1B6, 3'd4, 1, 0, 0, 2'b00, 0, 4'd3, 32'h1000, 0)};
    tv[2]  = '{ip0: 32'h2000, n: 5'd15, b: {{15{8'h26}}}, dop: 0, dad: 0,
               exp: mk(9'h000, 3'd0, 1, 0, 0, 2'b00, 0, 4'd15, 32'h2000, 1)};
    tv[3]  = '{ip0: 32'h3000, n: 5'd15, b: {{14{8'h26}}, 8'h90}, dop: 0, dad: 0,
               exp: mk(9'h090, 3'd0, 1, 0, 0, 2'b00, 0, 4'd15, 32'h3000, 0)};
    tv[4]  = '{ip0: 32'h4000, n: 5'd7, b: {8'h66, 8'h66, 8'hF2, 8'hF3, 8'h3E, 8'h36, 8'h90},
               dop: 1, dad: 0, exp: mk(9'h090, 3'd2, 1, 0, 0, 2'b11, 0, 4'd7, 32'h4000, 0)};
    tv[5]  = '{ip0: 32'h5000, n: 5'd1, b: {8'h90}, dop: 1, dad: 1,
               exp: mk(9'h090, 3'd3, 0, 1, 1, 2'b00, 0, 4'd1, 32'h5000, 0)};
    tv[6]  = '{ip0: 32'h6000, n: 5'd4, b: {8'hF0, 8'h67, 8'h0F, 8'h05}, dop: 0, dad: 0,
               exp: mk(9'h105, 3'd3, 0, 0, 1, 2'b00, 1, 4'd4, 32'h6000, 0)};
    tv[7]  = '{ip0: 32'h7000, n: 5'd2, b: {8'h0F, 8'h66}, dop: 1, dad: 0,
               exp: mk(9'h166, 3'd3, 0, 1, 0, 2'b00, 0, 4'd2, 32'h7000, 0)};
    tv[8]  = '{ip0: 32'h8000, n: 5'd3, b: {8'h65, 8'hF2, 8'h8B}, dop: 0, dad: 1,
               exp: mk(9'h08B, 3'd5, 1, 0, 1, 2'b10, 0, 4'd3, 32'h8000, 0)};
    tv[9]  = '{ip0: 32'h9000, n: 5'd15, b: {{13{8'h66}}, 8'h0F, 8'h05}, dop: 0, dad: 0,
               exp: mk(9'h105, 3'd3, 0, 1, 0, 2'b00, 0, 4'd15, 32'h9000, 0)};
    tv[10] = '{ip0: 32'hFFFF_FFFE, n: 5'd15, b: {{14{8'h66}}, 8'h0F}, dop: 0, dad: 0,
               exp: mk(9'h000, 3'd3, 0, 1, 0, 2'b00, 0, 4'd15, 32'hFFFF_FFFE, 1)};
    tv[11] = '{ip0: 32'hA000, n: 5'd5, b: {8'h3E, 8'hF3, 8'h2E, 8'hF2, 8'hC3}, dop: 0, dad: 0,
               exp: mk(9'h0C3, 3'd1, 1, 0, 0, 2'b10, 0, 4'd5, 32'hA000, 0)};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst.hdr_valid", 64'(bus.hdr_valid), 64'd0);
    chk("rst.ip",        64'(bus.ip),        64'd0);
    chk("rst.opcode",    64'(bus.opcode),    64'd0);
    chk("rst.seg_id",    64'(bus.seg_id),    64'd3);
    chk("rst.seg_pre",   64'(bus.seg_pre),   64'd0);
    chk("rst.opsize",    64'(bus.opsize),    64'd0);
    chk("rst.adsize",    64'(bus.adsize),    64'd0);
    chk("rst.rep",       64'(bus.rep),       64'd0);
    chk("rst.lock",      64'(bus.lock),      64'd0);
    chk("rst.len",       64'(bus.len),       64'd0);
    chk("rst.start_ip",  64'(bus.start_ip),  64'd0);
    chk("rst.fault",     64'(bus.fault),     64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, gap-free and immediate acceptance.
    for (int i = 0; i < 12; i++) begin
      do_flush(tv[i].ip0);
      bus.def_opsize = tv[i].dop;
      bus.def_adsize = tv[i].dad;
      feed(tv[i].b, int'(tv[i].n), int'(tv[i].n), 1'b0);
      take_hdr(got, 0);
      cmp_hdr($sformatf("vec%0d", i), got, tv[i].exp);
    end

    // Same as vector 0 but with in_valid gaps and a delayed hdr_ready.
    do_flush(tv[0].ip0);
    bus.def_opsize = 0; bus.def_adsize = 0;
    feed(tv[0].b, 4, 4, 1'b1);
    take_hdr(got, 2);
    cmp_hdr("vec0_gaps", got, tv[0].exp);

    // Header held while the sequencer stalls; stray bytes must be ignored.
    do_flush(32'h1000);
    feed(tv[1].b, 3, 3, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 8'h90;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("hold.hdr_valid", 64'(bus.hdr_valid), 64'd1);
      chk("hold.in_ready",  64'(bus.in_ready),  64'd0);
      chk("hold.opcode",    64'(bus.opcode),    64'h1B6);
      chk("hold.seg_id",    64'(bus.seg_id),    64'd4);
      chk("hold.len",       64'(bus.len),       64'd3);
      chk("hold.ip",        64'(bus.ip),        64'h1003);
    end
    bus.in_valid = 1'b0;
    bus.hdr_ready = 1'b1;
    @(posedge clk); #1;
    bus.hdr_ready = 1'b0;
    chk("release.hdr_valid", 64'(bus.hdr_valid), 64'd0);
    chk("release.in_ready",  64'(bus.in_ready),  64'd1);

    // Flush mid-decode (after 0F) with a byte presented that must be dropped.
    do_flush(32'h200);
    feed({8'h2E, 8'h0F}, 2, 2, 1'b0);
    bus.flush = 1'b1; bus.new_ip = 32'hFFFF_FFFF;
    bus.in_valid = 1'b1; bus.in_data = 8'h90;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush.ip",       64'(bus.ip),       64'hFFFF_FFFF);
    chk("flush.len",      64'(bus.len),      64'd0);
    chk("flush.in_ready", 64'(bus.in_ready), 64'd1);
    feed({8'hC3}, 1, 1, 1'b0);
    take_hdr(got, 0);
    cmp_hdr("flush_c3", got, mk(9'h0C3, 3'd3, 0, 0, 0, 2'b00, 0, 4'd1, 32'hFFFF_FFFF, 0));
    chk("flush_c3.ip_wrap", 64'(got.ip), 64'd0);

    // Back-to-back one-byte instructions: one per two cycles.
    do_flush(32'h300);
    bus.hdr_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h90;
    repeat (8) @(posedge clk);
    #1;
    bus.hdr_ready = 1'b0; bus.in_valid = 1'b0;
    chk("thru.ip", 64'(bus.ip), 64'h304);
    if (bus.hdr_valid) begin
      bus.hdr_ready = 1'b1; @(posedge clk); #1; bus.hdr_ready = 1'b0;
    end

    // Asynchronous reset while a header is held.
    do_flush(32'h400);
    feed({8'h90}, 1, 1, 1'b0);
    chk("prereset.hdr_valid", 64'(bus.hdr_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset.hdr_valid", 64'(bus.hdr_valid), 64'd0);
    chk("areset.ip",        64'(bus.ip),        64'd0);
    chk("areset.in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized instructions against the reference model.
    for (int k = 0; k < 48; k++) begin
      int pct;
      pct = (k % 5 == 0) ? 97 : 70;
      for (int i = 0; i < 16; i++)
        s[8*(15-i) +: 8] = ($urandom_range(0, 99) < pct) ? pool[$urandom_range(0, 11)]
                                                         : 8'($urandom_range(0, 255));
      ip0 = $urandom;
      dop = 1'($urandom_range(0, 1));
      dad = 1'($urandom_range(0, 1));
      exp_h = model(s, 16, dop, dad, ip0, used);
      do_flush(ip0);
      bus.def_opsize = dop;
      bus.def_adsize = dad;
      feed(s, 16, used, 1'b1);
      take_hdr(got, $urandom_range(0, 3));
      cmp_hdr($sformatf("rnd%0d", k), got, exp_h);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
